// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for the unified fetch/data memory port
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);

    state_t      state_q;
    logic [3:0]  streak_q;
    logic [2:0]  cnt_q;
    logic        owner_q;
    logic        we_q;
    logic        if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
    logic        mem_en_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;

    logic        any_req_d;
    logic        win_data_d;
    logic [3:0]  streak_d;

    // Data wins contention until it has taken STARVE_MAX contested grants in a row.
    always_comb begin
        any_req_d  = if_req | d_req;
        win_data_d = d_req & ~(if_req & (streak_q == STARVE_LIM));
        streak_d   = 4'd0;
        if (win_data_d && if_req)
            streak_d = (streak_q == STARVE_LIM) ? streak_q : streak_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            cnt_q       <= 3'd0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (any_req_d) begin
                        state_q     <= ISSUE;
                        owner_q     <= win_data_d;
                        streak_q    <= streak_d;
                        we_q        <= win_data_d & d_we;
                        if_gnt_q    <= ~win_data_d;
                        d_gnt_q     <= win_data_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_data_d & d_we;
                        mem_addr_q  <= win_data_d ? d_addr : if_addr;
                        mem_wdata_q <= d_wdata;
                    end else begin
                        state_q <= IDLE;
                        owner_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= RESP;
                        if (!owner_q) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            if (!we_q)
                                d_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule
